// File: rtl/he_pkg.sv
// he_pkg: constants and types shared by the histogram-equalisation output path.
package he_pkg;

    // Frame geometry at the default image size.
    localparam int IMAGE_WIDTH  = 660;
    localparam int IMAGE_HEIGHT = 440;
    localparam int NUM_PIXELS   = IMAGE_WIDTH * IMAGE_HEIGHT;

    // Pixel counter width; large enough for NUM_PIXELS (290400 < 2^19).
    localparam int PIX_CNT_W = 19;

    // One equalised pixel.
    typedef logic [7:0] pixel_t;

    // Packer state encoding.
    typedef enum logic [1:0] {
        PACK  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } pack_state_e;

endpackage

// File: rtl/he_word_skid.sv
// he_word_skid: one-word output register with valid/ready hold and same-cycle pop/load.
// The producer may only assert load_i while can_load_o is high.
module he_word_skid #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             last_i,
    input  logic             out_ready_i,
    output logic             can_load_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_last_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             last_q, last_d;

    // A new word fits when the register is empty or its word leaves this cycle.
    assign can_load_o = !valid_q || out_ready_i;

    // Next register contents: a load wins over a pop, so pop+load keeps valid high.
    always_comb begin
        // NOTE: every signal gets its hold value first so no latch is inferred.
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            last_d  = last_i;
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    // Output register; holds data and last stable while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            // NOTE: the data register is reset too, so out_data reads 0 while in reset.
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only; blocking ones here would race other flops.
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_last_o  = last_q;

endmodule

// File: rtl/he_pixel_packer.sv
// he_pixel_packer: packs equalised 8-bit pixels little-endian into PIX_PER_WORD-pixel words,
// flags the final word of the frame and raises a sticky frame_done after it is handed off.
// Optional feature: define HE_PACK_CHECKSUM_EN to add checksum[15:0], a mod-2^16 sum of
// every accepted pixel.
module he_pixel_packer #(
    parameter int IMAGE_WIDTH  = he_pkg::IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = he_pkg::IMAGE_HEIGHT,
    parameter int NUM_PIXELS   = IMAGE_WIDTH * IMAGE_HEIGHT,
    parameter int PIX_PER_WORD = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [7:0]                in_pixel,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [8*PIX_PER_WORD-1:0] out_data,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic                      frame_done
`ifdef HE_PACK_CHECKSUM_EN
    ,
    output logic [15:0]               checksum
`endif
);

    import he_pkg::*;

    localparam int LANE_W = $clog2(PIX_PER_WORD);
    localparam int WORD_W = 8 * PIX_PER_WORD;

    localparam logic [PIX_CNT_W-1:0] LAST_PIX_IDX = PIX_CNT_W'(NUM_PIXELS - 1);
    localparam logic [PIX_CNT_W-1:0] PIX_CNT_MAX  = PIX_CNT_W'(NUM_PIXELS);
    localparam logic [LANE_W-1:0]    LAST_LANE    = LANE_W'(PIX_PER_WORD - 1);

    pack_state_e          state_q, state_d;
    logic [LANE_W-1:0]    lane_q, lane_d;
    logic [WORD_W-1:0]    pack_q, pack_d;
    logic [PIX_CNT_W-1:0] pixel_cnt_q, pixel_cnt_d;

    pixel_t            pix;
    logic [WORD_W-1:0] word_full;
    logic              last_pix;
    logic              word_done;
    logic              can_load;
    logic              in_fire;
    logic              load;

    assign pix = in_pixel;

    // The pixel offered now is the last of the frame, or fills the top lane.
    assign last_pix  = (pixel_cnt_q == LAST_PIX_IDX);
    assign word_done = (lane_q == LAST_LANE) || last_pix;

    // Stall only when this pixel would complete a word the output register cannot take.
    // Gated by reset so the port reads 0 while reset is asserted.
    assign in_ready = reset && (state_q == PACK) && !(word_done && !can_load);
    assign in_fire  = in_valid && in_ready;
    assign load     = in_fire && word_done;

    // Pack register with the incoming pixel dropped into the current lane.
    always_comb begin
        word_full = pack_q;
        for (int i = 0; i < PIX_PER_WORD; i++) begin
            if (lane_q == LANE_W'(i)) begin
                word_full[8*i +: 8] = pix;
            end
        end
    end

    // Lane, pack register and pixel counter; the pack register is cleared on every
    // completed word so the unused lanes of a short final word stay zero.
    always_comb begin
        lane_d      = lane_q;
        pack_d      = pack_q;
        pixel_cnt_d = pixel_cnt_q;
        if (in_fire) begin
            if (pixel_cnt_q != PIX_CNT_MAX) begin
                pixel_cnt_d = pixel_cnt_q + 1'b1;
            end
            if (word_done) begin
                lane_d = '0;
                pack_d = '0;
            end else begin
                lane_d = lane_q + 1'b1;
                pack_d = word_full;
            end
        end
    end

    // Frame FSM: accept pixels, wait for the last word to leave, then stay done until reset.
    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        unique case (state_q)
            PACK: begin
                if (in_fire && last_pix) state_d = DRAIN;
            end
            DRAIN: begin
                if (out_valid && out_ready && out_last) state_d = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
            end
            default: begin
                state_d = PACK;
            end
        endcase
    end

    // State, lane, pack and counter registers; a reset discards any partial word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= PACK;
            lane_q      <= '0;
            pack_q      <= '0;
            pixel_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            pack_q      <= pack_d;
            pixel_cnt_q <= pixel_cnt_d;
        end
    end

    he_word_skid #(
        .WIDTH (WORD_W)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .load_i      (load),
        .data_i      (word_full),
        .last_i      (last_pix),
        .out_ready_i (out_ready),
        .can_load_o  (can_load),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_last_o  (out_last)
    );

`ifdef HE_PACK_CHECKSUM_EN
    logic [15:0] csum_q;

    // Running sum of accepted pixels; no handshakes occur after the frame, so it freezes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_q <= '0;
        end else if (in_fire) begin
            csum_q <= csum_q + {8'h00, pix};
        end
    end

    assign checksum = csum_q;
`endif

endmodule
